// File: rtl/vga_text_banner.sv
// vga_text_banner: one scaled line of runtime-writable glyphs over VGA video.
// Modes: static, blink, typewriter reveal, off; 2-stage registered pipeline.
// In : clk, rst_n, h_cnt/v_cnt/valid (pixel), mode, restart,
//      wr_en/wr_addr/wr_char (char buffer write port).
// Out: vgaRed/vgaGreen/vgaBlue, hit (banner owns pixel), done (reveal end).
// Option: VGA_TEXT_BANNER_CURSOR_EN adds a blinking typewriter cursor.
module vga_text_banner #(
  parameter logic [9:0]  X0            = 10'd265,
  parameter logic [9:0]  Y0            = 10'd120,
  parameter int          NUM_CHARS     = 16,
  parameter int          SCALE         = 1,
  parameter logic [11:0] FG_COLOR      = 12'hfff,
  parameter logic [11:0] BG_COLOR      = 12'h000,
  parameter int          BLINK_FRAMES  = 30,
  parameter int          REVEAL_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] h_cnt,
  input  logic [9:0] v_cnt,
  input  logic       valid,
  input  logic [1:0] mode,
  input  logic       restart,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [4:0] wr_char,
  output logic [3:0] vgaRed,
  output logic [3:0] vgaGreen,
  output logic [3:0] vgaBlue,
  output logic       hit,
  output logic       done
);

  localparam logic [1:0] M_STATIC = 2'd0;
  localparam logic [1:0] M_BLINK  = 2'd1;
  localparam logic [1:0] M_TYPE   = 2'd2;
  localparam logic [1:0] M_OFF    = 2'd3;

  localparam int SH = (SCALE == 4) ? 2 : (SCALE == 2) ? 1 : 0;
  localparam logic [10:0] RGN_W = 11'(NUM_CHARS * 13 * SCALE);
  localparam logic [10:0] RGN_H = 11'(15 * SCALE);

  // Stroke masks; bit 12 is glyph column 0.
  localparam logic [12:0] BAR   = 13'h0ffe;
  localparam logic [12:0] LEFT  = 13'h0e00;
  localparam logic [12:0] RIGHT = 13'h000e;
  localparam logic [12:0] CTR   = 13'h00e0;

  // Glyphs are built from nine 3-px strokes:
  // s = {top, mid, bottom, up-left, low-left,
  //      up-right, low-right, up-centre, low-centre}
  function automatic logic [12:0] glyph_row(
    input logic [4:0] code,
    input logic [3:0] row
  );
    logic [8:0]  s;
    logic [12:0] r;
    logic        top, mid, bot, up, lo;
    unique case (code)
      5'd1:    s = 9'b111110000;
      5'd2:    s = 9'b101000011;
      5'd3:    s = 9'b001011100;
      5'd4:    s = 9'b001110000;
      5'd5:    s = 9'b100111110;
      5'd6:    s = 9'b100111100;
      5'd7:    s = 9'b110111000;
      5'd8:    s = 9'b110111001;
      5'd9:    s = 9'b111100100;
      5'd10:   s = 9'b100000011;
      5'd11:   s = 9'b001111100;
      5'd12:   s = 9'b110111100;
      5'd13:   s = 9'b101110100;
      5'd14:   s = 9'b101111100;
      5'd15:   s = 9'b000101001;
      default: s = '0;
    endcase
    top = row <= 4'd2;
    mid = (row >= 4'd6) && (row <= 4'd8);
    bot = (row >= 4'd12) && (row <= 4'd14);
    up  = row <= 4'd7;
    lo  = (row >= 4'd7) && (row <= 4'd14);
    r = '0;
    if (s[8] && top) r = r | BAR;
    if (s[7] && mid) r = r | BAR;
    if (s[6] && bot) r = r | BAR;
    if (s[5] && up)  r = r | LEFT;
    if (s[4] && lo)  r = r | LEFT;
    if (s[3] && up)  r = r | RIGHT;
    if (s[2] && lo)  r = r | RIGHT;
    if (s[1] && up)  r = r | CTR;
    if (s[0] && lo)  r = r | CTR;
    return r;
  endfunction

  logic [4:0]  r_buf [32];
  logic        r_prev_zero;
  logic [15:0] r_bcnt;
  logic [15:0] r_rcnt;
  logic        r_phase;
  logic [5:0]  r_reveal;

  logic        r1_valid;
  logic        r1_in;
  logic [4:0]  r1_cell;
  logic [3:0]  r1_row;
  logic [3:0]  r1_col;
  logic [4:0]  r1_code;
  logic [11:0] r2_rgb;
  logic        r2_hit;

  logic [10:0] w_dx;
  logic [10:0] w_dy;
  logic [10:0] w_sx;
  logic        w_in;
  logic [4:0]  w_cell;
  logic [3:0]  w_col;
  logic [3:0]  w_row;
  logic [4:0]  w_code;
  logic        w_wr;
  logic        w_zero;
  logic        w_tick;
  logic        w_done;
  logic        w_adv;
  logic [12:0] w_rowbits;
  logic        w_bit;
  logic        w_allow;
  logic        w_cursor;
  logic        w_fg;

  // 11-bit offsets so the region never wraps past column 1023.
  assign w_dx   = {1'b0, h_cnt} - {1'b0, X0};
  assign w_dy   = {1'b0, v_cnt} - {1'b0, Y0};
  assign w_in   = (h_cnt >= X0) && (v_cnt >= Y0) &&
                  (w_dx < RGN_W) && (w_dy < RGN_H);
  assign w_sx   = w_dx >> SH;
  assign w_cell = 5'(w_sx / 11'd13);
  assign w_col  = 4'(w_sx % 11'd13);
  assign w_row  = 4'(w_dy >> SH);
  assign w_code = w_in ? r_buf[w_cell] : 5'd0;

  assign w_wr   = wr_en && ({1'b0, wr_addr} < 6'(NUM_CHARS));
  assign w_zero = (h_cnt == 10'd0) && (v_cnt == 10'd0);
  assign w_tick = w_zero && !r_prev_zero;
  assign w_done = (r_reveal == 6'(NUM_CHARS));
  assign w_adv  = (mode == M_TYPE) && !w_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_buf[i] <= '0;
    end else if (w_wr) begin
      r_buf[wr_addr] <= wr_char;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_zero <= 1'b0;
      r_bcnt      <= '0;
      r_rcnt      <= '0;
      r_phase     <= 1'b1;
      r_reveal    <= '0;
    end else begin
      r_prev_zero <= w_zero;
      if (restart) begin
        r_bcnt   <= '0;
        r_rcnt   <= '0;
        r_phase  <= 1'b1;
        r_reveal <= '0;
      end else if (w_tick) begin
        if (r_bcnt == 16'(BLINK_FRAMES - 1)) begin
          r_bcnt  <= '0;
          r_phase <= !r_phase;
        end else begin
          r_bcnt <= r_bcnt + 16'd1;
        end
        if (w_adv) begin
          if (r_rcnt == 16'(REVEAL_FRAMES - 1)) begin
            r_rcnt   <= '0;
            r_reveal <= r_reveal + 6'd1;
          end else begin
            r_rcnt <= r_rcnt + 16'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid <= 1'b0;
      r1_in    <= 1'b0;
      r1_cell  <= '0;
      r1_row   <= '0;
      r1_col   <= '0;
      r1_code  <= '0;
    end else begin
      r1_valid <= valid;
      r1_in    <= w_in;
      r1_cell  <= w_cell;
      r1_row   <= w_row;
      r1_col   <= w_col;
      r1_code  <= w_code;
    end
  end

  always_comb begin
    w_rowbits = glyph_row(r1_code, r1_row);
    w_bit     = w_rowbits[4'd12 - r1_col];
    w_allow   = 1'b0;
    unique case (mode)
      M_STATIC: w_allow = 1'b1;
      M_BLINK:  w_allow = r_phase;
      M_TYPE:   w_allow = ({1'b0, r1_cell} < r_reveal);
      default:  w_allow = 1'b0;
    endcase
    w_cursor = 1'b0;
`ifdef VGA_TEXT_BANNER_CURSOR_EN
    w_cursor = (mode == M_TYPE) && !w_done && r_phase &&
               ({1'b0, r1_cell} == r_reveal) &&
               (r1_row >= 4'd12) &&
               (r1_col != 4'd0) && (r1_col <= 4'd11);
`endif
    w_fg = (w_bit && w_allow) || w_cursor;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_rgb <= '0;
      r2_hit <= 1'b0;
    end else if (r1_valid && r1_in && (mode != M_OFF)) begin
      r2_rgb <= w_fg ? FG_COLOR : BG_COLOR;
      r2_hit <= 1'b1;
    end else begin
      r2_rgb <= '0;
      r2_hit <= 1'b0;
    end
  end

  assign vgaRed   = r2_rgb[11:8];
  assign vgaGreen = r2_rgb[7:4];
  assign vgaBlue  = r2_rgb[3:0];
  assign hit      = r2_hit;
  assign done     = w_done;

endmodule

// File: tb/tb_vga_text_banner.sv
// tb_vga_text_banner: two banner instances (SCALE 1 and clipped SCALE 2)
// against a geometric glyph model, table probes, sequences, random video.
`timescale 1ns/1ps
module tb_vga_text_banner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [9:0] h_cnt = '0;
  logic [9:0] v_cnt = '0;
  logic       valid = 1'b0;
  logic [1:0] mode = '0;
  logic       restart = 1'b0;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [4:0] wr_char = '0;
  logic [3:0] rA, gA, bA, rB, gB, bB;
  logic       hitA, doneA, hitB, doneB;

  always #5 clk = ~clk;

  vga_text_banner #(
    .X0(10'd265), .Y0(10'd120), .NUM_CHARS(16), .SCALE(1),
    .FG_COLOR(12'hfff), .BG_COLOR(12'h000),
    .BLINK_FRAMES(2), .REVEAL_FRAMES(2)
  ) dA (
    .clk(clk), .rst_n(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .valid(valid), .mode(mode), .restart(restart), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_char(wr_char), .vgaRed(rA),
    .vgaGreen(gA), .vgaBlue(bA), .hit(hitA), .done(doneA)
  );

  vga_text_banner #(
    .X0(10'd900), .Y0(10'd120), .NUM_CHARS(5), .SCALE(2),
    .FG_COLOR(12'h3a5), .BG_COLOR(12'h012),
    .BLINK_FRAMES(3), .REVEAL_FRAMES(1)
  ) dB (
    .clk(clk), .rst_n(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .valid(valid), .mode(mode), .restart(restart), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_char(wr_char), .vgaRed(rB),
    .vgaGreen(gB), .vgaBlue(bB), .hit(hitB), .done(doneB)
  );

  int total = 0;
  int bad = 0;

  // Per-instance parameters of the model.
  int P_X0[2] = '{265, 900};
  int P_Y0[2] = '{120, 120};
  int P_N[2]  = '{16, 5};
  int P_S[2]  = '{1, 2};
  int P_FG[2] = '{'hfff, 'h3a5};
  int P_BG[2] = '{'h000, 'h012};
  int P_BF[2] = '{2, 3};
  int P_RF[2] = '{2, 1};

  // Glyph shapes as lists of rectangles (see seg_on).
  string GL[16] = '{"", "TMBab", "TBef", "Bbcd", "Bab", "Tabcde",
                    "Tabcd", "TMabc", "TMabcf", "TMBad", "Tef",
                    "Babcd", "TMabcd", "TBabd", "TBabcd", "acf"};

  int m_buf[2][32];
  int m_nt[2];
  int m_tw[2];
  bit m_prevz;
  bit s1v[2], s1in[2];
  int s1cell[2], s1col[2], s1row[2], s1code[2];
  int e_rgb[2];
  bit e_hit[2];

  function automatic bit seg_on(byte s, int c, int r);
    case (s)
      "T": return c >= 1 && c <= 11 && r <= 2;
      "M": return c >= 1 && c <= 11 && r >= 6 && r <= 8;
      "B": return c >= 1 && c <= 11 && r >= 12 && r <= 14;
      "a": return c >= 1 && c <= 3 && r <= 7;
      "b": return c >= 1 && c <= 3 && r >= 7 && r <= 14;
      "c": return c >= 9 && c <= 11 && r <= 7;
      "d": return c >= 9 && c <= 11 && r >= 7 && r <= 14;
      "e": return c >= 5 && c <= 7 && r <= 7;
      "f": return c >= 5 && c <= 7 && r >= 7 && r <= 14;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit glyph_px(int code, int c, int r);
    string g;
    if (code > 15) return 1'b0;
    g = GL[code];
    for (int k = 0; k < g.len(); k++)
      if (seg_on(g[k], c, r)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int rev(int k);
    return m_tw[k] / P_RF[k];
  endfunction

  function automatic bit phs(int k);
    return ((m_nt[k] / P_BF[k]) % 2) == 0;
  endfunction

  task automatic model_reset();
    m_prevz = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) m_buf[k][i] = 0;
      m_nt[k] = 0; m_tw[k] = 0;
      s1v[k] = 0; s1in[k] = 0; s1cell[k] = 0;
      s1col[k] = 0; s1row[k] = 0; s1code[k] = 0;
      e_rgb[k] = 0; e_hit[k] = 0;
    end
  endtask

  task automatic model_edge();
    bit tick, fg;
    int dx, dy, w, md;
    md = int'(mode);
    tick = (h_cnt == 0) && (v_cnt == 0) && !m_prevz;
    for (int k = 0; k < 2; k++) begin
      e_rgb[k] = 0; e_hit[k] = 0;
      if (s1v[k] && s1in[k] && md != 3) begin
        fg = glyph_px(s1code[k], s1col[k], s1row[k]) &&
             (md == 0 || (md == 1 && phs(k)) ||
              (md == 2 && s1cell[k] < rev(k)));
`ifdef VGA_TEXT_BANNER_CURSOR_EN
        if (md == 2 && rev(k) < P_N[k] && s1cell[k] == rev(k) &&
            s1row[k] >= 12 && s1col[k] >= 1 && s1col[k] <= 11 &&
            phs(k)) fg = 1'b1;
`endif
        e_hit[k] = 1'b1;
        e_rgb[k] = fg ? P_FG[k] : P_BG[k];
      end
      w = 13 * P_S[k];
      dx = int'(h_cnt) - P_X0[k];
      dy = int'(v_cnt) - P_Y0[k];
      s1v[k] = valid;
      s1in[k] = dx >= 0 && dy >= 0 && dx < P_N[k] * w && dy < 15 * P_S[k];
      s1cell[k] = s1in[k] ? dx / w : 0;
      s1col[k] = s1in[k] ? (dx % w) / P_S[k] : 0;
      s1row[k] = s1in[k] ? dy / P_S[k] : 0;
      s1code[k] = s1in[k] ? m_buf[k][s1cell[k]] : 0;
      if (wr_en && int'(wr_addr) < P_N[k])
        m_buf[k][wr_addr] = int'(wr_char);
      if (restart) begin
        m_nt[k] = 0; m_tw[k] = 0;
      end else if (tick) begin
        m_nt[k]++;
        if (md == 2 && rev(k) < P_N[k]) m_tw[k]++;
      end
    end
    m_prevz = (h_cnt == 0) && (v_cnt == 0);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("A rgb", int'({rA, gA, bA}), e_rgb[0]);
    chk("A hit", int'(hitA), int'(e_hit[0]));
    chk("A done", int'(doneA), int'(rev(0) == P_N[0]));
    chk("B rgb", int'({rB, gB, bB}), e_rgb[1]);
    chk("B hit", int'(hitB), int'(e_hit[1]));
    chk("B done", int'(doneB), int'(rev(1) == P_N[1]));
  endtask

  task automatic probe(input int h, input int v, input bit vl,
                       input int md);
    h_cnt = 10'(h); v_cnt = 10'(v); valid = vl; mode = 2'(md);
    step();
    step();
  endtask

  task automatic tick1();
    h_cnt = '0; v_cnt = '0;
    step();
  endtask

  typedef struct {
    int h; int v; bit vl; int md; int rgb; bit hit;
  } probe_t;

  probe_t tab[17];
  int slime[5] = '{9, 4, 2, 5, 1};
  int bexp[4] = '{'hfff, 'h000, 'h000, 'hfff};

  initial begin
    tab[0]  = '{267, 120, 1, 0, 'hfff, 1};
    tab[1]  = '{265, 120, 1, 0, 'h000, 1};
    tab[2]  = '{264, 120, 1, 0, 'h000, 0};
    tab[3]  = '{266, 120, 1, 0, 'hfff, 1};
    tab[4]  = '{277, 120, 1, 0, 'h000, 1};
    tab[5]  = '{278, 120, 1, 0, 'h000, 1};
    tab[6]  = '{279, 121, 1, 0, 'hfff, 1};
    tab[7]  = '{285, 121, 1, 0, 'h000, 1};
    tab[8]  = '{272, 130, 1, 0, 'h000, 1};
    tab[9]  = '{275, 130, 1, 0, 'hfff, 1};
    tab[10] = '{267, 134, 1, 0, 'hfff, 1};
    tab[11] = '{267, 135, 1, 0, 'h000, 0};
    tab[12] = '{472, 120, 1, 0, 'h000, 1};
    tab[13] = '{473, 120, 1, 0, 'h000, 0};
    tab[14] = '{267, 120, 0, 0, 'h000, 0};
    tab[15] = '{267, 120, 1, 3, 'h000, 0};
    tab[16] = '{267, 119, 1, 0, 'h000, 0};

    model_reset();
    #1 rst_n = 1'b0;
    #3;
    chk("reset A rgb", int'({rA, gA, bA}), 0);
    chk("reset A hit", int'(hitA), 0);
    chk("reset A done", int'(doneA), 0);
    chk("reset B hit", int'(hitB), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_char = 5'(slime[i]);
      step();
    end
    wr_en = 1'b0;

    for (int i = 0; i < 17; i++) begin
      probe(tab[i].h, tab[i].v, tab[i].vl, tab[i].md);
      chk($sformatf("tab%0d rgb", i), int'({rA, gA, bA}), tab[i].rgb);
      chk($sformatf("tab%0d hit", i), int'(hitA), int'(tab[i].hit));
    end

    restart = 1'b1; step(); restart = 1'b0;
    probe(267, 120, 1, 1);
    chk("blink start", int'({rA, gA, bA}), 'hfff);
    for (int k = 0; k < 4; k++) begin
      tick1();
      probe(267, 120, 1, 1);
      chk($sformatf("blink t%0d rgb", k + 1), int'({rA, gA, bA}), bexp[k]);
      chk($sformatf("blink t%0d hit", k + 1), int'(hitA), 1);
    end

    mode = 2'd2;
    restart = 1'b1; step(); restart = 1'b0;
    probe(1008, 120, 1, 2);
    chk("type start rgb", int'({rB, gB, bB}), 'h012);
    chk("type start done", int'(doneB), 0);
    for (int k = 1; k <= 6; k++) begin
      tick1();
      probe(1008, 120, 1, 2);
      chk($sformatf("type t%0d rgb", k), int'({rB, gB, bB}),
          (k >= 5) ? 'h3a5 : 'h012);
      chk($sformatf("type t%0d done", k), int'(doneB), int'(k >= 5));
    end

    h_cnt = '0; v_cnt = '0; restart = 1'b1;
    step();
    restart = 1'b0;
    probe(904, 120, 1, 2);
    chk("restart+tick rgb", int'({rB, gB, bB}), 'h012);
    chk("restart+tick done", int'(doneB), 0);
    tick1();
    probe(904, 120, 1, 2);
    chk("after tick rgb", int'({rB, gB, bB}), 'h3a5);

    mode = 2'd0;
    wr_en = 1'b1; wr_addr = 5'd20; wr_char = 5'd0;
    step();
    wr_en = 1'b0;
    probe(319, 120, 1, 0);
    chk("wr oob cell4", int'({rA, gA, bA}), 'hfff);

    h_cnt = 10'd267; v_cnt = 10'd120; valid = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd0; wr_char = 5'd0;
    step();
    wr_en = 1'b0;
    step();
    chk("wr same old", int'({rA, gA, bA}), 'hfff);
    step();
    chk("wr same new", int'({rA, gA, bA}), 'h000);
    chk("wr same hit", int'(hitA), 1);

    probe(925, 149, 1, 0);
    chk("scale2 rgb", int'({rB, gB, bB}), 'h012);
    chk("scale2 hit", int'(hitB), 1);

    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async A rgb", int'({rA, gA, bA}), 0);
    chk("async A hit", int'(hitA), 0);
    chk("async B rgb", int'({rB, gB, bB}), 0);
    chk("async B hit", int'(hitB), 0);
    chk("async B done", int'(doneB), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("post rst 1clk", int'(hitB), 0);
    step();
    chk("post rst 2clk", int'(hitB), 1);

    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1; wr_addr = 5'(i); wr_char = 5'($urandom_range(0, 31));
      step();
    end
    wr_en = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 4) begin
        h_cnt = '0; v_cnt = '0;
      end else if (r < 75) begin
        h_cnt = 10'($urandom_range(255, 1023));
        v_cnt = 10'($urandom_range(115, 155));
      end else begin
        h_cnt = 10'($urandom_range(0, 1023));
        v_cnt = 10'($urandom_range(0, 524));
      end
      valid = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
      restart = ($urandom_range(0, 99) == 0);
      wr_en = ($urandom_range(0, 19) == 0);
      wr_addr = 5'($urandom_range(0, 31));
      wr_char = 5'($urandom_range(0, 31));
      step();
    end
    restart = 1'b0; wr_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
